// File: rtl/cache_pkg.sv
// Shared widths, line/beat types and FSM encoding for the cache-line burst adaptor.
package cache_pkg;
    localparam int LINE_W     = 256;
    localparam int BURST_W    = 64;
    localparam int ADDR_W     = 32;
    localparam int BEATS      = LINE_W / BURST_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int OFFSET_W   = $clog2(LINE_W / 8);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [LINE_W-1:0]     line_t;
    typedef logic [BURST_W-1:0]    burst_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
    typedef logic [ADDR_W-1:0]     addr_t;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WR   = ST_WR,
        DONE = ST_DONE
    } adaptor_state_e;

    function automatic addr_t line_align(input addr_t a);
        addr_t r;
        r = a;
        r[OFFSET_W-1:0] = '0;
        return r;
    endfunction
endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load, beat-indexed write and beat-indexed read mux.
module line_beat_buffer
    import cache_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  line_t     i_line,
    input  logic      i_beat_we,
    input  beat_idx_t i_beat_idx,
    input  burst_t    i_beat,
    output line_t     o_line,
    output burst_t    o_beat
);
    line_t r_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
        end else if (i_load) begin
            r_buf <= i_line;
        end else if (i_beat_we) begin
            r_buf[int'(i_beat_idx)*BURST_W +: BURST_W] <= i_beat;
        end
    end

    assign o_line = r_buf;
    assign o_beat = r_buf[int'(i_beat_idx)*BURST_W +: BURST_W];
endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Turns one cache-line read/write into a BEATS-beat memory burst and answers with one resp_o pulse.
// Defining ADAPTOR_STATS_EN adds saturating line/stall statistics outputs.
module cacheline_burst_adaptor
    import cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  line_t  line_i,
    output line_t  line_o,
    input  addr_t  address_i,
    input  logic   read_i,
    input  logic   write_i,
    output logic   resp_o,
    input  burst_t burst_i,
    output burst_t burst_o,
    output addr_t  address_o,
    output logic   read_o,
    output logic   write_o,
    input  logic   resp_i
`ifdef ADAPTOR_STATS_EN
    ,
    output logic [31:0] stat_rd_lines,
    output logic [31:0] stat_wr_lines,
    output logic [31:0] stat_stall_cycles
`endif
);
    // state | meaning
    // IDLE  | waiting for a cache request
    // RD    | read burst, collecting beats into the buffer
    // WR    | write burst, streaming buffer beats out
    // DONE  | one-cycle resp_o to the cache
    adaptor_state_e r_state;
    beat_idx_t      r_beat;
    addr_t          r_addr;

    logic   w_last;
    logic   w_busy;
    logic   w_load;
    logic   w_beat_we;
    burst_t w_rd_beat;

    assign w_last    = (r_beat == beat_idx_t'(BEATS - 1));
    assign w_busy    = (r_state == RD) || (r_state == WR);
    assign w_load    = (r_state == IDLE) && !read_i && write_i;
    assign w_beat_we = (r_state == RD) && resp_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (read_i) begin
                        r_addr  <= line_align(address_i);
                        r_state <= RD;
                    end else if (write_i) begin
                        r_addr  <= line_align(address_i);
                        r_state <= WR;
                    end
                end
                RD, WR: begin
                    if (resp_i) begin
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    line_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_line     (line_i),
        .i_beat_we  (w_beat_we),
        .i_beat_idx (r_beat),
        .i_beat     (burst_i),
        .o_line     (line_o),
        .o_beat     (w_rd_beat)
    );

    assign read_o    = (r_state == RD);
    assign write_o   = (r_state == WR);
    assign resp_o    = (r_state == DONE);
    assign address_o = r_addr;
    assign burst_o   = (r_state == WR) ? w_rd_beat : '0;

`ifdef ADAPTOR_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if ((r_state == RD) && resp_i && w_last && (r_stat_rd != '1)) begin
                r_stat_rd <= r_stat_rd + 32'd1;
            end
            if ((r_state == WR) && resp_i && w_last && (r_stat_wr != '1)) begin
                r_stat_wr <= r_stat_wr + 32'd1;
            end
            if (w_busy && !resp_i && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_rd_lines     = r_stat_rd;
    assign stat_wr_lines     = r_stat_wr;
    assign stat_stall_cycles = r_stat_stall;
`else
    logic w_unused;
    assign w_unused = w_busy;
`endif
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed, table-driven bench for cacheline_burst_adaptor plus hand-written reset/stray-beat sequences.
module tb_cacheline_burst_adaptor;
    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
`ifdef ADAPTOR_STATS_EN
    logic [31:0]  stat_rd_lines;
    logic [31:0]  stat_wr_lines;
    logic [31:0]  stat_stall_cycles;
`endif

    int n_checks = 0;
    int n_err    = 0;

    cacheline_burst_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
`ifdef ADAPTOR_STATS_EN
        ,
        .stat_rd_lines     (stat_rd_lines),
        .stat_wr_lines     (stat_wr_lines),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         is_wr;
        logic         both;
        logic         stray;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [15:0]  pat;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int beats;
        int j;
        int edges;
        int ones;
        int k;
        logic bitv;
        logic [1:0] exp_rw;

        exp_rw = v.is_wr ? 2'b01 : 2'b10;
        ones = 0;
        k = 0;
        while (ones < 4) begin
            bitv = (k < 16) ? v.pat[k] : 1'b1;
            if (bitv) ones++;
            k++;
        end

        resp_i    = 1'b0;
        read_i    = !v.is_wr;
        write_i   = v.is_wr || v.both;
        address_i = v.addr;
        line_i    = v.is_wr ? v.line : ~v.line;
        step();
        edges = 1;
        read_i  = 1'b0;
        write_i = 1'b0;
        line_i  = '0;
        chk("burst_started", 256'({read_o, write_o}), 256'(exp_rw));
        chk("address_o", 256'(address_o), 256'(v.exp_addr));

        beats = 0;
        j = 0;
        while (beats < 4 && j < 40) begin
            resp_i  = (j < 16) ? v.pat[j] : 1'b1;
            burst_i = resp_i ? v.line[beats*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            chk("busy_rw", 256'({read_o, write_o}), 256'(exp_rw));
            chk("no_early_resp", 256'(resp_o), 256'(0));
            if (v.is_wr) chk("burst_o_beat", 256'(burst_o), 256'(v.line[beats*64 +: 64]));
            if (resp_i) beats++;
            step();
            edges++;
            j++;
        end
        resp_i  = v.stray;
        burst_i = '0;
        chk("beats_within_budget", 256'(beats), 256'(4));
        chk("resp_o_done", 256'(resp_o), 256'(1));
        chk("rw_dropped", 256'({read_o, write_o}), 256'(0));
        chk("line_o", line_o, v.line);
        chk("latency", 256'(edges), 256'(1 + k));
        chk("address_hold", 256'(address_o), 256'(v.exp_addr));
        step();
        chk("resp_o_single", 256'(resp_o), 256'(0));
        chk("idle_rw", 256'({read_o, write_o}), 256'(0));
        if (v.stray) begin
            step();
            chk("stray_idle_rw", 256'({read_o, write_o, resp_o}), 256'(0));
            resp_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fresh;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    16'hFFFF, 32'h0000_1220};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_ABCD,
                    {64'hDEAD_0000_0000_0003, 64'h0000_0000_0000_0002,
                     64'h0000_0000_0000_0001, 64'h0000_0000_0000_BEEF},
                    16'h0059, 32'h0000_ABC0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h8000_0040,
                    {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                     64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
                    16'hFFFF, 32'h8000_0040};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF,
                    {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001},
                    16'h0035, 32'hFFFF_FFE0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_105F,
                    {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                     64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                    16'hFFFF, 32'h0000_1040};

        rst = 1'b0;
        read_i = 1'b0;
        write_i = 1'b0;
        resp_i = 1'b0;
        address_i = 32'h1234_5678;
        line_i = {4{64'hFFFF_0000_FFFF_0000}};
        burst_i = 64'h1;
        step();
        step();
        chk("reset_line_o", line_o, 256'(0));
        chk("reset_burst_o", 256'(burst_o), 256'(0));
        chk("reset_address_o", 256'(address_o), 256'(0));
        chk("reset_ctrl", 256'({read_o, write_o, resp_o}), 256'(0));
        address_i = '0;
        line_i = '0;
        burst_i = '0;
        #2 rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i]);
`ifdef ADAPTOR_STATS_EN
            if (i == 2) begin
                chk("stat_rd_lines", 256'(stat_rd_lines), 256'(2));
                chk("stat_wr_lines", 256'(stat_wr_lines), 256'(1));
                chk("stat_stall_cycles", 256'(stat_stall_cycles), 256'(3));
            end
`endif
        end

        // Stray beats while idle must not start anything or move the beat counter.
        resp_i = 1'b1;
        burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_resp_idle", 256'({read_o, write_o, resp_o}), 256'(0));
        end
        resp_i = 1'b0;
        burst_i = '0;
        vecs[1].pat = 16'hFFFF;
        run_txn(vecs[1]);

        // Reset in the middle of a read burst, after two beats.
        read_i = 1'b1;
        address_i = 32'h0000_0040;
        step();
        read_i = 1'b0;
        resp_i = 1'b1;
        burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        step();
        resp_i = 1'b0;
        chk("pre_reset_read_o", 256'(read_o), 256'(1));
        #2 rst = 1'b0;
        #1;
        chk("reset_mid_read_o", 256'({read_o, write_o}), 256'(0));
        chk("reset_mid_resp_o", 256'(resp_o), 256'(0));
        chk("reset_mid_line_o", line_o, 256'(0));
        step();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_quiet", 256'({read_o, write_o, resp_o}), 256'(0));
        end

        fresh = '{1'b0, 1'b0, 1'b0, 32'h0000_0047,
                  {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                   64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001},
                  16'hFFFF, 32'h0000_0040};
        run_txn(fresh);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
